// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the ARM pipeline control slice: the FSM state
// encoding, the register-index width and the default counter width.
package arm_pkg;

   localparam int unsigned REG_IDX_W = 4;
   localparam int unsigned CNT_W_DEF = 16;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } pipe_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with a synchronous clear. The clear takes priority
// over the increment.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] r_count;

   // Count up on inc and hold at all-ones; clear wins over the increment.
   always_ff @(posedge clk) begin
      if (clr)
         r_count <= '0;
      else if (inc && (r_count != '1))
         r_count <= r_count + 1'b1;
   end

   assign count = r_count;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: owns the en/clr strobes of the IF/ID,
// ID/EXE, EXE/MEM and MEM/WB registers. It freezes the pipe while data
// memory is not ready, flushes the front end on taken branches and inserts
// bubbles on read-after-write hazards.
// Optional feature macro: PIPE_FORWARDING_EN (operand forwarding present,
// so only load-use in EXE stalls).
module pipe_hazard_ctrl
   import arm_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_W       = CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 id_valid,
   input  logic [REG_IDX_W-1:0] src1,
   input  logic [REG_IDX_W-1:0] src2,
   input  logic                 two_src,
   input  logic [REG_IDX_W-1:0] exe_dest,
   input  logic                 exe_wb_en,
   input  logic                 exe_mem_r_en,
   input  logic [REG_IDX_W-1:0] mem_dest,
   input  logic                 mem_wb_en,
   input  logic                 branch_taken,
   input  logic                 mem_req,
   input  logic                 mem_ready,
   output logic                 if_en,
   output logic                 if_clr,
   output logic                 id_en,
   output logic                 id_clr,
   output logic                 exe_en,
   output logic                 mem_en,
   output logic                 mem_err,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     flush_cnt
);

   localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 1);

   pipe_state_t r_state, w_next_state;
   logic [15:0] r_tmo, w_tmo_next;
   logic        r_mem_err;
   logic        w_err_set;
   logic        w_wait;
   logic        w_exe_match, w_mem_match, w_hazard;
   logic        w_stall_inc, w_flush_inc;
   logic        w_unused_ok;

   // A source matches a producer when src1 equals it, or src2 does and is read.
   assign w_exe_match = (exe_dest == src1) || (two_src && (exe_dest == src2));
   assign w_mem_match = (mem_dest == src1) || (two_src && (mem_dest == src2));

`ifdef PIPE_FORWARDING_EN
   assign w_hazard    = id_valid && exe_mem_r_en && exe_wb_en && w_exe_match;
   assign w_unused_ok = &{1'b0, mem_wb_en, w_mem_match};
`else
   assign w_hazard    = id_valid && ((exe_wb_en && w_exe_match) ||
                                     (mem_wb_en && w_mem_match));
   assign w_unused_ok = &{1'b0, exe_mem_r_en};
`endif

   assign w_wait = ((r_state == RUN) && mem_req && !mem_ready) ||
                   ((r_state == MEM_WAIT) && !mem_ready);

   // Next state, timeout tracking and strobes by priority:
   // reset, memory wait, branch flush, data hazard, normal.
   always_comb begin
      w_next_state = r_state;
      w_tmo_next   = '0;
      w_err_set    = 1'b0;
      w_stall_inc  = 1'b0;
      w_flush_inc  = 1'b0;
      if_en        = 1'b1;
      if_clr       = 1'b0;
      id_en        = 1'b1;
      id_clr       = 1'b0;
      exe_en       = 1'b1;
      mem_en       = 1'b1;
      if (!rst) begin
         w_next_state = RUN;
         if_en        = 1'b0;
         id_en        = 1'b0;
         exe_en       = 1'b0;
         mem_en       = 1'b0;
         if_clr       = 1'b1;
         id_clr       = 1'b1;
      end else if (w_wait) begin
         if_en  = 1'b0;
         id_en  = 1'b0;
         exe_en = 1'b0;
         mem_en = 1'b0;
         if (r_state == RUN) begin
            w_next_state = MEM_WAIT;
         end else if (r_tmo == TMO_LAST) begin
            // Last permitted wait cycle: abandon the access and flag it.
            w_err_set    = 1'b1;
            w_next_state = RUN;
         end else begin
            w_tmo_next = r_tmo + 16'd1;
         end
      end else begin
         // Not waiting (including the MEM_WAIT exit cycle): behave as RUN.
         w_next_state = RUN;
         if (branch_taken) begin
            if_clr      = 1'b1;
            id_clr      = 1'b1;
            w_flush_inc = 1'b1;
         end else if (w_hazard) begin
            if_en       = 1'b0;
            id_clr      = 1'b1;
            w_stall_inc = 1'b1;
         end
      end
   end

   // State, timeout counter and sticky error flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= RUN;
         r_tmo     <= '0;
         r_mem_err <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_tmo   <= w_tmo_next;
         if (w_err_set)
            r_mem_err <= 1'b1;
      end
   end

   assign mem_err = r_mem_err;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .clr   (!rst),
      .inc   (w_stall_inc),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .clr   (!rst),
      .inc   (w_flush_inc),
      .count (flush_cnt)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MEM_TIMEOUT=8, CNT_W=4).
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid, two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
   logic       branch_taken, mem_req, mem_ready;
   logic [3:0] src1, src2, exe_dest, mem_dest;
   logic       if_en, if_clr, id_en, id_clr, exe_en, mem_en, mem_err;
   logic [3:0] stall_cnt, flush_cnt;

   int unsigned total = 0;
   int unsigned bad   = 0;
   int unsigned exp_stall = 0;
   int unsigned exp_flush = 0;

   // Strobe vector order: {if_en, if_clr, id_en, id_clr, exe_en, mem_en}
   localparam logic [5:0] S_NORMAL = 6'b101011;
   localparam logic [5:0] S_HAZARD = 6'b001111;
   localparam logic [5:0] S_FLUSH  = 6'b111111;
   localparam logic [5:0] S_FREEZE = 6'b000000;
   localparam logic [5:0] S_RESET  = 6'b010100;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(8), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
      .two_src(two_src), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
      .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
      .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
      .if_en(if_en), .if_clr(if_clr), .id_en(id_en), .id_clr(id_clr),
      .exe_en(exe_en), .mem_en(mem_en), .mem_err(mem_err),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_s(input string tag, input logic [5:0] exp);
      chk(tag, {26'd0, if_en, if_clr, id_en, id_clr, exe_en, mem_en}, {26'd0, exp});
   endtask

   task automatic chk_cnt(input string tag);
      chk({tag, "_stall"}, {28'd0, stall_cnt}, exp_stall);
      chk({tag, "_flush"}, {28'd0, flush_cnt}, exp_flush);
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_valid = 0; two_src = 0; exe_wb_en = 0; exe_mem_r_en = 0; mem_wb_en = 0;
      branch_taken = 0; mem_req = 0; mem_ready = 0;
      src1 = 4'd0; src2 = 4'd0; exe_dest = 4'd0; mem_dest = 4'd0;
   endtask

   task automatic load_use();
      id_valid = 1; exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 4'd3; src1 = 4'd3;
   endtask

   initial begin
      rst = 0;
      idle();
      #1;
      chk_s("reset_strobes", S_RESET);
      tick();
      chk_cnt("reset");
      chk("reset_err", {31'd0, mem_err}, 32'd0);

      rst = 1;
      #1;
      chk_s("normal", S_NORMAL);
      tick();

      // Load-use stall
      load_use();
      #1;
      chk_s("load_use", S_HAZARD);
      tick();
      exp_stall++;
      chk_cnt("load_use");

      // MEM-stage RAW on src2
      idle();
      id_valid = 1; mem_wb_en = 1; mem_dest = 4'd5; src2 = 4'd5; src1 = 4'd1; two_src = 1;
      #1;
`ifdef PIPE_FORWARDING_EN
      chk_s("mem_raw", S_NORMAL);
`else
      chk_s("mem_raw", S_HAZARD);
      exp_stall++;
`endif
      tick();
      chk_cnt("mem_raw");
      two_src = 0;
      #1;
      chk_s("mem_raw_one_src", S_NORMAL);
      tick();
      chk_cnt("mem_raw_one_src");

      // Branch together with load-use: flush wins
      idle();
      load_use();
      branch_taken = 1;
      #1;
      chk_s("branch_hazard", S_FLUSH);
      tick();
      exp_flush++;
      chk_cnt("branch_hazard");

      // Memory wait: four frozen cycles then ready
      idle();
      mem_req = 1;
      for (int i = 0; i < 4; i++) begin
         #0;
         chk_s($sformatf("mem_wait_%0d", i), S_FREEZE);
         tick();
      end
      mem_ready = 1;
      #1;
      chk_s("mem_wait_exit", S_NORMAL);
      tick();
      idle();
      #1;
      chk_s("mem_wait_back_run", S_NORMAL);
      tick();

      // Branch held during a wait is flushed once in the exit cycle
      mem_req = 1; branch_taken = 1;
      #1;
      chk_s("br_wait_0", S_FREEZE);
      tick();
      chk_s("br_wait_1", S_FREEZE);
      tick();
      mem_ready = 1;
      #1;
      chk_s("br_wait_exit", S_FLUSH);
      tick();
      exp_flush++;
      idle();
      chk_cnt("br_wait");

      // Timeout after 8 MEM_WAIT cycles
      mem_req = 1;
      tick();
      for (int k = 1; k <= 8; k++) begin
         chk_s($sformatf("tmo_freeze_%0d", k), S_FREEZE);
         tick();
         chk($sformatf("tmo_err_%0d", k), {31'd0, mem_err}, (k == 8) ? 32'd1 : 32'd0);
      end
      mem_req = 0;
      #1;
      chk_s("tmo_back_run", S_NORMAL);
      tick();
      chk("tmo_err_sticky", {31'd0, mem_err}, 32'd1);

      // Saturation of the 4-bit stall counter
      load_use();
      for (int n = 0; n < 20; n++) begin
         tick();
         if (exp_stall < 15) exp_stall++;
      end
      chk_cnt("saturate");
      chk("saturate_15", {28'd0, stall_cnt}, 32'd15);

      // Reset has priority over a pending memory wait
      idle();
      mem_req = 1;
      rst = 0;
      #1;
      chk_s("reset2_strobes", S_RESET);
      tick();
      exp_stall = 0; exp_flush = 0;
      chk_cnt("reset2");
      chk("reset2_err", {31'd0, mem_err}, 32'd0);
      rst = 1; mem_req = 0;
      #1;
      chk_s("after_reset2", S_NORMAL);
      tick();

      // Reset asserted mid-MEM_WAIT returns to RUN
      mem_req = 1;
      tick();
      tick();
      rst = 0;
      tick();
      rst = 1; mem_req = 0; mem_ready = 0;
      #1;
      chk_s("reset_mid_wait_run", S_NORMAL);
      tick();
      chk_cnt("reset_mid_wait");

      // Ready in the same cycle as the request: no wait state
      mem_req = 1; mem_ready = 1;
      #1;
      chk_s("req_ready_same", S_NORMAL);
      tick();
      mem_req = 0; mem_ready = 0;
      #1;
      chk_s("req_ready_no_wait", S_NORMAL);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
